// File: rtl/xor_acc_pkg.sv
// Package: xor_acc_pkg
//
// Shared definitions for the streaming XOR checksum accumulator.
//   state_t    - accumulator FSM states (ACCUM: taking words, HOLD: result pending)
//   len_width  - width needed to hold a word count of 0..max_len inclusive
package xor_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // The count field must represent max_len itself, not just max_len-1.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/xor_reduce.sv
// Module: xor_reduce
//
// Combinational XOR reduction of a WIDTH-bit word down to one parity bit.
// The result is 1 when the word holds an odd number of set bits.
//
// Ports:
//   data    in   WIDTH   word to reduce
//   parity  out  1       XOR of every bit of data
module xor_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    // A flat reduction operator; synthesis builds a balanced XOR tree from it.
    assign parity = ^data;

endmodule

// File: rtl/xor_checksum_acc.sv
// Module: xor_checksum_acc
//
// Streaming XOR checksum/parity accumulator. WIDTH-bit words arrive on a
// valid/ready stream and are XOR-folded per frame. A frame closes on in_last
// or automatically after MAX_LEN words; one registered result is then offered
// on the output handshake (checksum, parity, word count, overflow flag).
//
// Ports:
//   clk           in   1       rising-edge clock
//   reset         in   1       synchronous active-high reset
//   in_valid      in   1       input word valid
//   in_ready      out  1       block accepts a word this cycle
//   in_data       in   WIDTH   input word
//   in_last       in   1       word closes its frame
//   out_valid     out  1       result valid
//   out_ready     in   1       consumer accepts result
//   out_sum       out  WIDTH   XOR of all words in the frame
//   out_parity    out  1       parity over every bit of the frame
//   out_len       out  LEN_W   words in the frame, 1..MAX_LEN
//   out_overflow  out  1       frame closed at MAX_LEN without in_last
module xor_checksum_acc
    import xor_acc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = len_width(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [LEN_W-1:0] out_len,
    output logic             out_overflow
);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   acc_q;
    logic [LEN_W-1:0]   cnt_q;

    logic [WIDTH-1:0]   acc_n;
    logic [LEN_W-1:0]   cnt_n;
    logic               beat;
    logic               at_max;
    logic               close_frame;
    logic               parity_n;

    // Handshake signals are decoded purely from the state register, so there
    // is never a combinational path from out_ready through to in_ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);

    xor_reduce #(
        .WIDTH (WIDTH)
    ) u_parity (
        .data   (acc_n),
        .parity (parity_n)
    );

    // Next accumulator/count values and the frame-close decision. A frame
    // closes either on an explicit last word or when the count hits MAX_LEN.
    always_comb begin
        acc_n       = acc_q ^ in_data;
        cnt_n       = cnt_q + 1'b1;
        beat        = in_valid && (state_q == ACCUM);
        at_max      = (cnt_n == LEN_W'(MAX_LEN));
        close_frame = beat && (in_last || at_max);
    end

    // Next-state logic: one result handshake per frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: begin
                if (close_frame) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State, accumulator, counter and result registers. Results are only
    // written on a closing beat, so they stay stable through HOLD; after the
    // handshake they keep their stale values until the next frame closes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_sum      <= '0;
            out_parity   <= 1'b0;
            out_len      <= '0;
            out_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (beat) begin
                if (close_frame) begin
                    out_sum      <= acc_n;
                    out_parity   <= parity_n;
                    out_len      <= cnt_n;
                    out_overflow <= ~in_last & at_max;
                    acc_q        <= '0;
                    cnt_q        <= '0;
                end else begin
                    acc_q <= acc_n;
                    cnt_q <= cnt_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_checksum_acc.sv
// Testbench: tb_xor_checksum_acc
//
// Directed table of words with hand-computed frame results, hand-written
// sequences for back-pressure and reset corner cases, and a streaming run
// of directed plus random frames checked against an XOR scoreboard.
module tb_xor_checksum_acc;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;
    localparam int LEN_W   = 3;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_parity;
    logic [LEN_W-1:0] out_len;
    logic             out_overflow;

    int tests;
    int errors;

    xor_checksum_acc #(
        .WIDTH   (WIDTH),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_parity   (out_parity),
        .out_len      (out_len),
        .out_overflow (out_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       exp_valid;
        logic [7:0] exp_sum;
        logic       exp_par;
        logic [2:0] exp_len;
        logic       exp_ovf;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } word_t;

    typedef logic [12:0] result_t;

    vec_t    vecs[$];
    word_t   stream[$];
    result_t sb[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one word for exactly one clock edge; DUT must be in ACCUM.
    task automatic applyStimulus(input logic [7:0] data, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic [7:0] sum, input logic par,
                               input logic [2:0] len, input logic ovf);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, " out_sum"}, 32'(out_sum), 32'(sum));
        checkOutput({tag, " out_parity"}, 32'(out_parity), 32'(par));
        checkOutput({tag, " out_len"}, 32'(out_len), 32'(len));
        checkOutput({tag, " out_overflow"}, 32'(out_overflow), 32'(ovf));
        checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic addVec(input logic [7:0] d, input logic l, input logic v,
                          input logic [7:0] s, input logic p, input logic [2:0] n,
                          input logic o);
        vec_t t;
        t.data = d; t.last = l; t.exp_valid = v; t.exp_sum = s;
        t.exp_par = p; t.exp_len = n; t.exp_ovf = o;
        vecs.push_back(t);
    endtask

    task automatic addWord(input logic [7:0] d, input logic l);
        word_t w;
        w.data = d;
        w.last = l;
        stream.push_back(w);
    endtask

    logic stop_mon;
    int   results_seen;
    int   bubbles;

    initial begin
        tests     = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        stop_mon  = 1'b0;
        results_seen = 0;
        bubbles   = 0;

        // Frame A5,0F,F0 -> 5A; single 01; overflow at 4 words; new frame 3C;
        // in_last exactly on the 4th word gives no overflow.
        addVec(8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        addVec(8'h0F, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        addVec(8'hF0, 1'b1, 1'b1, 8'h5A, 1'b0, 3'd3, 1'b0);
        addVec(8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 3'd1, 1'b0);
        addVec(8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        addVec(8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        addVec(8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        addVec(8'h88, 1'b0, 1'b1, 8'hFF, 1'b0, 3'd4, 1'b1);
        addVec(8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 3'd1, 1'b0);
        addVec(8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        addVec(8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        addVec(8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        addVec(8'h08, 1'b1, 1'b1, 8'h0F, 1'b0, 3'd4, 1'b0);
        addVec(8'h07, 1'b1, 1'b1, 8'h07, 1'b1, 3'd1, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_sum", 32'(out_sum), 32'd0);
        checkOutput("reset out_parity", 32'(out_parity), 32'd0);
        checkOutput("reset out_len", 32'(out_len), 32'd0);
        checkOutput("reset out_overflow", 32'(out_overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].data, vecs[i].last);
            checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkResult($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_par,
                            vecs[i].exp_len, vecs[i].exp_ovf);
                @(posedge clk);
                #1;
                checkOutput($sformatf("vec%0d release out_valid", i), 32'(out_valid), 32'd0);
                checkOutput($sformatf("vec%0d release in_ready", i), 32'(in_ready), 32'd1);
            end
        end

        // Back-pressure: result held stable, input beats refused
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(8'h55, 1'b1);
        checkResult("hold", 8'h55, 1'b0, 3'd1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h77;
            in_last  = 1'b1;
            checkResult($sformatf("hold c%0d", c), 8'h55, 1'b0, 3'd1, 1'b0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("hold release out_valid", 32'(out_valid), 32'd0);
        checkOutput("hold release in_ready", 32'(in_ready), 32'd1);
        applyStimulus(8'h3C, 1'b1);
        checkResult("after hold", 8'h3C, 1'b0, 3'd1, 1'b0);
        @(posedge clk);
        #1;

        // Reset mid-frame discards partial accumulation
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(8'h3C, 1'b1);
        checkResult("post reset", 8'h3C, 1'b0, 3'd1, 1'b0);
        @(posedge clk);
        #1;

        // Reset while a result is pending drops it
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(8'h12, 1'b1);
        checkOutput("pending out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("pending reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("pending reset out_sum", 32'(out_sum), 32'd0);
        checkOutput("pending reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Streaming: directed frames {01,02 last},{04 last} then random frames,
        // some longer than MAX_LEN so they split with overflow.
        addWord(8'h01, 1'b0);
        addWord(8'h02, 1'b1);
        addWord(8'h04, 1'b1);
        for (int f = 0; f < 1000; f++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                addWord(8'($urandom), k == n - 1);
            end
        end

        fork
            begin : driver
                logic [7:0] m_acc;
                int         m_cnt;
                m_acc = '0;
                m_cnt = 0;
                for (int i = 0; i < stream.size(); i++) begin
                    int guard;
                    @(negedge clk);
                    in_valid = 1'b1;
                    in_data  = stream[i].data;
                    in_last  = stream[i].last;
                    guard    = 0;
                    while (!in_ready && guard < 10) begin
                        @(negedge clk);
                        guard++;
                    end
                    if (!in_ready) begin
                        checkOutput("stream in_ready timeout", 32'(in_ready), 32'd1);
                        break;
                    end
                    m_acc = m_acc ^ stream[i].data;
                    m_cnt++;
                    if (stream[i].last || m_cnt == MAX_LEN) begin
                        sb.push_back({m_acc, ^m_acc, 3'(m_cnt),
                                      !stream[i].last && (m_cnt == MAX_LEN)});
                        m_acc = '0;
                        m_cnt = 0;
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b0;
                repeat (5) @(negedge clk);
                stop_mon = 1'b1;
            end
            begin : monitor
                while (!stop_mon) begin
                    @(negedge clk);
                    if (!in_ready) bubbles++;
                    if (out_valid && out_ready) begin
                        result_t got;
                        got = {out_sum, out_parity, out_len, out_overflow};
                        if (sb.size() == 0) begin
                            checkOutput("stream unexpected result", 32'(got), 32'd0);
                        end else begin
                            result_t exp;
                            exp = sb.pop_front();
                            if (results_seen == 0)
                                checkOutput("stream first 03/len2", 32'(got), 32'({8'h03, 1'b0, 3'd2, 1'b0}));
                            if (results_seen == 1)
                                checkOutput("stream second 04/len1", 32'(got), 32'({8'h04, 1'b1, 3'd1, 1'b0}));
                            checkOutput($sformatf("stream result %0d", results_seen), 32'(got), 32'(exp));
                        end
                        results_seen++;
                    end
                end
            end
        join

        checkOutput("stream scoreboard drained", 32'(sb.size()), 32'd0);
        checkOutput("stream bubbles per result", 32'(bubbles), 32'(results_seen));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
